// File: rtl/td4_core_p_pkg.sv
// rtl/td4_core_p_pkg.sv - shared opcodes, selectors and FSM state type for the TD4 core
package td4_pkg;

  // Opcodes; every executing instruction computes dest <- src + imm.
  localparam logic [3:0] OP_ADDA  = 4'b0000;
  localparam logic [3:0] OP_MOVAB = 4'b0001;
  localparam logic [3:0] OP_INA   = 4'b0010;
  localparam logic [3:0] OP_MOVAI = 4'b0011;
  localparam logic [3:0] OP_MOVBA = 4'b0100;
  localparam logic [3:0] OP_ADDB  = 4'b0101;
  localparam logic [3:0] OP_INB   = 4'b0110;
  localparam logic [3:0] OP_MOVBI = 4'b0111;
  localparam logic [3:0] OP_HLT   = 4'b1000;
  localparam logic [3:0] OP_OUTB  = 4'b1001;
  localparam logic [3:0] OP_OUTI  = 4'b1011;
  localparam logic [3:0] OP_JNC   = 4'b1110;
  localparam logic [3:0] OP_JMP   = 4'b1111;

  // ALU source operand selector.
  localparam logic [1:0] SRC_A    = 2'd0;
  localparam logic [1:0] SRC_B    = 2'd1;
  localparam logic [1:0] SRC_IN   = 2'd2;
  localparam logic [1:0] SRC_ZERO = 2'd3;

  // Bit positions in the load-enable vector.
  localparam int LD_A   = 0;
  localparam int LD_B   = 1;
  localparam int LD_OUT = 2;
  localparam int LD_PC  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } state_t;

  // Instruction word width: 4-bit opcode above a W-bit immediate.
  function automatic int instr_w(input int w);
    return w + 4;
  endfunction

endpackage

// File: rtl/td4_core_p_if.sv
// rtl/td4_core_p_if.sv - instruction-memory fetch handshake between core and program store
interface td4_core_p_if #(
  parameter int W = 4
);
  logic                             imem_req;
  logic [W-1:0]                     imem_addr;
  logic                             imem_ack;
  logic [td4_pkg::instr_w(W)-1:0]   imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_data
  );
endinterface

// File: rtl/td4_core_p_decode.sv
// rtl/td4_core_p_decode.sv - combinational TD4 opcode decoder
module td4_decode
  import td4_pkg::*;
(
  input  logic [3:0] op_i,
  input  logic       carry_i,
  output logic [1:0] src_sel_o,
  output logic [3:0] ld_o,
  output logic       is_hlt_o,
  output logic       is_nop_o
);

  // Map opcode (and carry, for JNC) to source select and destination loads.
  always_comb begin
    src_sel_o = SRC_ZERO;
    ld_o      = '0;
    is_hlt_o  = 1'b0;
    is_nop_o  = 1'b0;
    case (op_i)
      OP_ADDA:  begin src_sel_o = SRC_A;    ld_o[LD_A]   = 1'b1; end
      OP_MOVAB: begin src_sel_o = SRC_B;    ld_o[LD_A]   = 1'b1; end
      OP_INA:   begin src_sel_o = SRC_IN;   ld_o[LD_A]   = 1'b1; end
      OP_MOVAI: begin src_sel_o = SRC_ZERO; ld_o[LD_A]   = 1'b1; end
      OP_MOVBA: begin src_sel_o = SRC_A;    ld_o[LD_B]   = 1'b1; end
      OP_ADDB:  begin src_sel_o = SRC_B;    ld_o[LD_B]   = 1'b1; end
      OP_INB:   begin src_sel_o = SRC_IN;   ld_o[LD_B]   = 1'b1; end
      OP_MOVBI: begin src_sel_o = SRC_ZERO; ld_o[LD_B]   = 1'b1; end
      OP_OUTB:  begin src_sel_o = SRC_B;    ld_o[LD_OUT] = 1'b1; end
      OP_OUTI:  begin src_sel_o = SRC_ZERO; ld_o[LD_OUT] = 1'b1; end
      OP_JMP:   begin src_sel_o = SRC_ZERO; ld_o[LD_PC]  = 1'b1; end
      // 0+imm never overflows, so carry is always cleared whether or not the jump is taken.
      OP_JNC:   begin src_sel_o = SRC_ZERO; ld_o[LD_PC]  = ~carry_i; end
      OP_HLT:   is_hlt_o = 1'b1;
      default:  is_nop_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/td4_core_p.sv
// rtl/td4_core_p.sv - width-generic TD4 core with fetch handshake and run/step/halt control
module td4_core_p
  import td4_pkg::*;
#(
  parameter int           W        = 4,
  parameter logic [W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              step,
  td4_core_p_if.master      imem,
  input  logic [W-1:0]      inp,
  output logic [W-1:0]      outp,
  output logic [W-1:0]      pc,
  output logic              carry,
  output logic              halted
);

  localparam int           IW    = instr_w(W);
  localparam logic [W-1:0] PC_ONE = {{(W-1){1'b0}}, 1'b1};

  state_t         state_q, state_d;
  logic           tok_q, tok_d;
  logic [IW-1:0]  ir_q;
  logic [W-1:0]   a_q, b_q, out_q, pc_q;
  logic           carry_q;

  logic [3:0]     op;
  logic [W-1:0]   imm;
  logic [1:0]     src_sel;
  logic [3:0]     ld;
  logic           is_hlt, is_nop;
  logic [W-1:0]   src;
  logic [W:0]     sum;
  logic [W-1:0]   pc_inc;

  assign op     = ir_q[IW-1:W];
  assign imm    = ir_q[W-1:0];
  assign pc_inc = pc_q + PC_ONE;

  td4_decode u_decode (
    .op_i      (op),
    .carry_i   (carry_q),
    .src_sel_o (src_sel),
    .ld_o      (ld),
    .is_hlt_o  (is_hlt),
    .is_nop_o  (is_nop)
  );

  // ALU source mux; inp is sampled live during EXEC.
  always_comb begin
    src = '0;
    case (src_sel)
      SRC_A:   src = a_q;
      SRC_B:   src = b_q;
      SRC_IN:  src = inp;
      default: src = '0;
    endcase
  end

  assign sum = {1'b0, src} + {1'b0, imm};

  // Next-state logic; a step token forces a halt after its single instruction even if run rises meanwhile.
  always_comb begin
    state_d = state_q;
    tok_d   = tok_q;
    case (state_q)
      ST_IDLE: begin
        if (run || step) begin
          state_d = ST_FETCH;
          tok_d   = ~run;
        end
      end
      ST_FETCH: begin
        if (imem.imem_ack) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (run && !is_hlt && !tok_q) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
          tok_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tok_d   = 1'b0;
      end
    endcase
  end

  // FSM state and step-token registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      tok_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tok_q   <= tok_d;
    end
  end

  // Instruction capture on ack and single-edge commit of registers, pc and carry in EXEC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      pc_q    <= RESET_PC;
      carry_q <= 1'b0;
    end else begin
      if (state_q == ST_FETCH && imem.imem_ack) ir_q <= imem.imem_data;
      if (state_q == ST_EXEC) begin
        if (ld[LD_A])   a_q   <= sum[W-1:0];
        if (ld[LD_B])   b_q   <= sum[W-1:0];
        if (ld[LD_OUT]) out_q <= sum[W-1:0];
        pc_q <= ld[LD_PC] ? sum[W-1:0] : pc_inc;
        if (!is_hlt && !is_nop) carry_q <= sum[W];
      end
    end
  end

  // Request follows the registered state, so an async reset drops it immediately.
  assign imem.imem_req  = (state_q == ST_FETCH);
  assign imem.imem_addr = pc_q;
  assign outp           = out_q;
  assign pc             = pc_q;
  assign carry          = carry_q;
  assign halted         = (state_q == ST_IDLE);

endmodule

// File: tb/tb_td4_core_p.sv
// tb/tb_td4_core_p.sv - directed self-checking bench for td4_core_p at W=4 and W=8
module tb_td4_core_p;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- W=4 instance, immediate ack ----------------
  logic       rst4 = 1'b0, run4 = 1'b0, step4 = 1'b0, ack_en4 = 1'b1;
  logic [3:0] inp4 = 4'h0;
  logic [3:0] outp4, pc4;
  logic       carry4, halted4;
  logic [7:0] mem4 [16];
  int         exec_cnt4 = 0;

  td4_core_p_if #(.W(4)) if4 ();
  assign if4.imem_ack  = if4.imem_req && ack_en4;
  assign if4.imem_data = mem4[if4.imem_addr];

  td4_core_p #(.W(4), .RESET_PC(4'h0)) dut4 (
    .clk(clk), .reset(rst4), .run(run4), .step(step4), .imem(if4.master),
    .inp(inp4), .outp(outp4), .pc(pc4), .carry(carry4), .halted(halted4)
  );

  always @(posedge clk) if (rst4 && !if4.imem_req && !halted4) exec_cnt4 <= exec_cnt4 + 1;

  // ---------------- W=8 instance, ack delayed 3 cycles ----------------
  logic        rst8 = 1'b0, run8 = 1'b0, step8 = 1'b0;
  logic [7:0]  inp8 = 8'h00;
  logic [7:0]  outp8, pc8;
  logic        carry8, halted8;
  logic [11:0] mem8 [256];
  int          cnt8 = 0;

  td4_core_p_if #(.W(8)) if8 ();
  assign if8.imem_ack  = if8.imem_req && (cnt8 == 3);
  assign if8.imem_data = mem8[if8.imem_addr];

  always @(posedge clk) begin
    if (!if8.imem_req || if8.imem_ack) cnt8 <= 0;
    else cnt8 <= cnt8 + 1;
  end

  td4_core_p #(.W(8), .RESET_PC(8'h10)) dut8 (
    .clk(clk), .reset(rst8), .run(run8), .step(step8), .imem(if8.master),
    .inp(inp8), .outp(outp8), .pc(pc8), .carry(carry8), .halted(halted8)
  );

  task automatic wait_commit4();
    int n = 0;
    while (!(!if4.imem_req && !halted4) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("timeout4", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_commit8();
    int n = 0;
    while (!(!if8.imem_req && !halted8) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("timeout8", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic step_once4();
    @(negedge clk);
    step4 = 1'b1;
    @(negedge clk);
    step4 = 1'b0;
    wait_commit4();
  endtask

  initial begin
    int t0;
    int base;
    int n;

    for (int i = 0; i < 16; i++) mem4[i] = 8'hA0;
    mem4[0]  = 8'h33;  // MOV A,3
    mem4[1]  = 8'h05;  // ADD A,5
    mem4[2]  = 8'h92;  // OUT B,2
    mem4[3]  = 8'h09;  // ADD A,9
    mem4[4]  = 8'h0F;  // ADD A,15
    mem4[5]  = 8'hE7;  // JNC 7
    mem4[6]  = 8'hE7;  // JNC 7
    mem4[7]  = 8'hFF;  // JMP 15
    mem4[15] = 8'hA0;  // NOP
    for (int i = 0; i < 256; i++) mem8[i] = 12'hA00;
    mem8[8'h10] = 12'hBA5;  // OUT Im 0xA5
    mem8[8'h11] = 12'h800;  // HLT

    repeat (3) @(posedge clk);
    #1;
    check("rst_pc4",     pc4, 4'h0);
    check("rst_outp4",   outp4, 4'h0);
    check("rst_carry4",  carry4, 1'b0);
    check("rst_halted4", halted4, 1'b1);
    check("rst_req4",    if4.imem_req, 1'b0);
    check("rst_pc8",     pc8, 8'h10);

    @(negedge clk);
    rst4 = 1'b1;
    run4 = 1'b1;

    wait_commit4();
    t0 = cyc;
    check("mov_a",  dut4.a_q, 4'h3);
    check("mov_pc", pc4, 4'h1);
    wait_commit4();
    check("add_a",      dut4.a_q, 4'h8);
    check("add_carry",  carry4, 1'b0);
    check("add_period", cyc - t0, 2);
    wait_commit4();
    check("outb", outp4, 4'h2);
    wait_commit4();
    check("add9_a",     dut4.a_q, 4'h1);
    check("add9_carry", carry4, 1'b1);
    wait_commit4();
    check("add15_a",     dut4.a_q, 4'h0);
    check("add15_carry", carry4, 1'b1);
    wait_commit4();
    check("jnc1_pc",    pc4, 4'h6);
    check("jnc1_carry", carry4, 1'b0);
    wait_commit4();
    check("jnc2_pc", pc4, 4'h7);
    wait_commit4();
    check("jmp_pc", pc4, 4'hF);
    wait_commit4();
    check("wrap_pc", pc4, 4'h0);

    // run drops while the next fetch is in flight: that instruction still executes.
    run4 = 1'b0;
    wait_commit4();
    check("runfall_pc",     pc4, 4'h1);
    check("runfall_halted", halted4, 1'b1);

    base = exec_cnt4;
    for (int k = 0; k < 3; k++) begin
      step_once4();
      check("step_halted", halted4, 1'b1);
    end
    repeat (4) @(posedge clk);
    #1;
    check("step_count",   exec_cnt4 - base, 3);
    check("step_pc",      pc4, 4'h4);
    check("step_a",       dut4.a_q, 4'h1);
    check("step_carry",   carry4, 1'b1);
    check("step_halted2", halted4, 1'b1);

    // HLT at address 2 with run held high.
    @(negedge clk);
    rst4 = 1'b0;
    mem4[2] = 8'h80;
    mem4[3] = 8'hB9;  // OUT Im 9
    mem4[4] = 8'h0F;  // ADD A,15
    @(negedge clk);
    rst4 = 1'b1;
    run4 = 1'b1;
    wait_commit4();
    wait_commit4();
    wait_commit4();
    run4 = 1'b0;
    check("hlt_halted", halted4, 1'b1);
    check("hlt_pc",     pc4, 4'h3);
    check("hlt_a",      dut4.a_q, 4'h8);

    step_once4();
    step_once4();
    check("pre_pc",    pc4, 4'h5);
    check("pre_outp",  outp4, 4'h9);
    check("pre_carry", carry4, 1'b1);

    // Stall a fetch at pc=5 and reset in the middle of it.
    ack_en4 = 1'b0;
    @(negedge clk);
    run4 = 1'b1;
    repeat (3) @(negedge clk);
    check("stall_req",  if4.imem_req, 1'b1);
    check("stall_addr", if4.imem_addr, 4'h5);
    #1;
    rst4 = 1'b0;
    #1;
    check("midrst_req",    if4.imem_req, 1'b0);
    check("midrst_pc",     pc4, 4'h0);
    check("midrst_outp",   outp4, 4'h0);
    check("midrst_carry",  carry4, 1'b0);
    check("midrst_halted", halted4, 1'b1);
    run4 = 1'b0;
    ack_en4 = 1'b1;

    // W=8 with a slow program store.
    @(negedge clk);
    rst8 = 1'b1;
    run8 = 1'b1;
    n = 0;
    while (!if8.imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("timeout8_req", 32'd0, 32'd1);
    for (int k = 0; k < 3; k++) begin
      check("w8_req",  if8.imem_req, 1'b1);
      check("w8_addr", if8.imem_addr, 8'h10);
      check("w8_ack",  if8.imem_ack, 1'b0);
      @(negedge clk);
    end
    check("w8_ack_late", if8.imem_ack, 1'b1);
    check("w8_addr_late", if8.imem_addr, 8'h10);
    wait_commit8();
    check("w8_outp",  outp8, 8'hA5);
    check("w8_pc",    pc8, 8'h11);
    check("w8_carry", carry8, 1'b0);
    wait_commit8();
    run8 = 1'b0;
    check("w8_hlt_halted", halted8, 1'b1);
    check("w8_hlt_pc",     pc8, 8'h12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/td4_core_p.md
Name: td4_core_p

Overview:
- Parametrised next-generation TD4 processor core: width-generic datapath (A, B, OUT, PC), registered carry flag, external instruction-memory handshake replacing the combinational ROM, and run/step/halt control.
- Same 12-instruction TD4 ISA plus HLT.
- Sits between an external program store and the board I/O.

Parameters:
- W, 4, data/immediate/PC width; instruction word is 4+W bits (opcode [W+3:W], imm [W-1:0]); legal range 4..16
- RESET_PC, 0, PC value loaded on reset

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- run  in  1  level: 1 = free-run, 0 = halt after the current instruction
- step  in  1  one-cycle pulse: execute exactly one instruction while run=0
- imem_req  out  1  fetch request, held until acknowledged
- imem_addr  out  W  fetch address (= PC), stable while imem_req=1
- imem_ack  in  1  memory acknowledge; imem_data valid in the same cycle
- imem_data  in  4+W  instruction word
- inp  in  W  input port
- outp  out  W  output port register
- pc  out  W  program counter
- carry  out  1  carry flag
- halted  out  1  core in IDLE state

Behaviour:
- Reset (async, reset=0) values: A=B=0, outp=0, pc=RESET_PC, carry=0, state=IDLE, imem_req=0, halted=1.
- FSM states: IDLE, FETCH, EXEC.
  - IDLE: halted=1. Go to FETCH if run=1 or step=1. A step is latched as a one-instruction token.
  - FETCH: imem_req=1, imem_addr=pc. On imem_ack=1, capture imem_data into the IR and go to EXEC. No timeout; the core waits indefinitely.
  - EXEC: commit one instruction, then go to FETCH if run=1 and no HLT was executed; otherwise go to IDLE and clear the step token.
- Minimum instruction period is 2 cycles (ack in the first FETCH cycle).
- ALU: sum = {1'b0,src} + {1'b0,imm}, W+1 bits. Result = sum[W-1:0], carry_out = sum[W].
- Every executed TD4 instruction loads carry with carry_out. MOV and JMP therefore clear carry unless src+imm overflows.
- Opcodes, as dest <- src+imm:
  - 0000 ADD A,Im: A <- A+imm
  - 0101 ADD B,Im: B <- B+imm
  - 0011 MOV A,Im: A <- 0+imm
  - 0111 MOV B,Im: B <- 0+imm
  - 0001 MOV A,B: A <- B+imm
  - 0100 MOV B,A: B <- A+imm
  - 0010 IN A: A <- inp+imm
  - 0110 IN B: B <- inp+imm
  - 1001 OUT B: outp <- B+imm
  - 1011 OUT Im: outp <- 0+imm
  - 1111 JMP: pc <- 0+imm
  - 1110 JNC: pc <- imm if carry==0 before this instruction, else pc+1; carry <- 0
  - 1000 HLT: pc <- pc+1, carry unchanged, core goes to IDLE
  - 1010, 1100, 1101: NOP, pc+1, carry unchanged
- Non-jump instructions: pc <- pc+1, wrapping modulo 2^W (all-ones -> 0).
- Register write, pc and carry update all occur on the EXEC clock edge. inp is sampled in EXEC.
- run falling during FETCH: the pending fetch completes and that instruction executes before the core halts.
- step with run=1: ignored.
- step pulses while not IDLE: ignored.
- Reset mid-FETCH: imem_req drops asynchronously; the memory side must tolerate an abandoned request.
- imem_ack while not in FETCH: ignored.

Decomposition:
- Package td4_pkg: opcode localparams (OP_ADDA..OP_HLT), FSM state enum, function instr_w(W)=W+4.
- One sub-module td4_decode: combinational decoder, op + carry -> {src_sel[1:0], ld[3:0], is_hlt, is_nop}.
- Register file, ALU, PC and FSM stay in td4_core_p.

Test Plan:
- W=4, program {MOV A,3; ADD A,5; OUT B...}, immediate acks: after ADD, A=8 and carry=0. Then ADD A,9 gives A=1, carry=1. Each instruction takes 2 cycles.
- Sequence ADD A,15 (A=1 -> 0, carry=1); JNC 7; JNC 7 -> the first JNC falls through (pc+1) and clears carry; the second jumps to 7.
- Loop at pc=15 with NOP -> pc wraps to 0.
- W=8, ack delayed 3 cycles -> imem_addr and imem_req stable throughout, then OUT Im 0xA5 gives outp=0xA5.
- run=0, three step pulses -> exactly 3 instructions, halted=1 between steps.
- HLT at addr 2 with run=1 -> halted rises, pc=3.
- Reset asserted mid-FETCH at pc=5 -> imem_req=0 immediately, pc=RESET_PC, outp=0, carry=0.
